// File: rtl/riscv_pkg.sv
// Shared types and constants for the riscv32 fetch/decode stage.
package riscv_pkg;

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state;

  localparam logic [6:0]         OPC_OP_IMM  = 7'b0010011;
  localparam logic [INSTR_W-1:0] INSTR_ECALL = 32'h0000_0073;

  // Decoded I-type fields as presented to the datapath.
  typedef struct packed {
    logic [11:0] imm12;
    logic [4:0]  rs1;
    logic [2:0]  opcode;
    logic [4:0]  rd;
  } itype_fields_t;

  // addi x0, x0, 0
  localparam itype_fields_t NOP_FIELDS = '{imm12: 12'h000, rs1: 5'd0, opcode: 3'd0, rd: 5'd0};

endpackage

// File: rtl/itype_decode.sv
// Combinational I-type field slicing with OP-IMM and ECALL classification.
module itype_decode
  import riscv_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output itype_fields_t      fields_c,
  output logic               is_op_imm_c,
  output logic               is_ecall_c
);

  assign fields_c.imm12  = instr[31:20];
  assign fields_c.rs1    = instr[19:15];
  assign fields_c.opcode = instr[14:12];
  assign fields_c.rd     = instr[11:7];

  assign is_op_imm_c = (instr[6:0] == OPC_OP_IMM);
  assign is_ecall_c  = (instr == INSTR_ECALL);

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: fetches RV32I words, presents OP-IMM fields for a fixed
// number of cycles, and halts on ECALL or any non-OP-IMM instruction.
module fetch_decode
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PC_BITS     = 8,
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_BITS-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [WIDTH-1:0]   imem_rdata,
  output logic [2:0]         opcode,
  output logic [4:0]         rd,
  output logic [4:0]         rs1,
  output logic [11:0]        imm12,
  output logic               issue,
  output logic               halt,
  output logic               illegal
);

  localparam int unsigned      CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  fetch_state         state_q, state_d;
  logic [PC_BITS-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  itype_fields_t      fields_q, fields_d;
  logic               req_q, req_d;
  logic               issue_q, issue_d;
  logic               halt_q, halt_d;
  logic               illegal_q, illegal_d;

  itype_fields_t      dec_fields;
  logic               dec_op_imm;
  logic               dec_ecall;

  itype_decode u_decode (
    .instr       (imem_rdata),
    .fields_c    (dec_fields),
    .is_op_imm_c (dec_op_imm),
    .is_ecall_c  (dec_ecall)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; every output comes straight from one of these
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      cnt_q     <= '0;
      fields_q  <= NOP_FIELDS;
      req_q     <= 1'b0;
      issue_q   <= 1'b0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      fields_q  <= fields_d;
      req_q     <= req_d;
      issue_q   <= issue_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and next-register values; req_d/fields_d look one cycle ahead
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    fields_d  = NOP_FIELDS;
    req_d     = 1'b0;
    issue_d   = 1'b0;
    halt_d    = halt_q;
    illegal_d = illegal_q;

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = FETCH;
          req_d   = 1'b1;
        end
      end

      FETCH: begin
        req_d = 1'b1;
        if (imem_ack) begin
          req_d = 1'b0;
          if (dec_op_imm) begin
            state_d  = HOLD;
            fields_d = dec_fields;
            cnt_d    = '0;
            issue_d  = 1'b1;
          end else begin
            state_d   = HALT;
            halt_d    = 1'b1;
            illegal_d = !dec_ecall;
          end
        end
      end

      HOLD: begin
        fields_d = fields_q;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          pc_d     = pc_q + PC_BITS'(1);
          fields_d = NOP_FIELDS;
          cnt_d    = '0;
          if (run) begin
            state_d = FETCH;
            req_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      HALT: begin
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign opcode    = fields_q.opcode;
  assign rd        = fields_q.rd;
  assign rs1       = fields_q.rs1;
  assign imm12     = fields_q.imm12;
  assign issue     = issue_q;
  assign halt      = halt_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode with a small PC space to exercise wrap.
module tb_fetch_decode;

  localparam int unsigned PC_BITS = 2;
  localparam int unsigned HOLD    = 3;
  localparam int unsigned DEPTH   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               run;
  logic               imem_req;
  logic [PC_BITS-1:0] imem_addr;
  logic               imem_ack;
  logic [31:0]        imem_rdata;
  logic [2:0]         opcode;
  logic [4:0]         rd;
  logic [4:0]         rs1;
  logic [11:0]        imm12;
  logic               issue;
  logic               halt;
  logic               illegal;

  logic [31:0] mem [DEPTH];
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          pc       = 0;

  fetch_decode #(.WIDTH(32), .PC_BITS(PC_BITS), .HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .opcode     (opcode),
    .rd         (rd),
    .rs1        (rs1),
    .imm12      (imm12),
    .issue      (issue),
    .halt       (halt),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Memory answers after wait_cfg cycles of an outstanding request.
  assign imem_ack   = imem_req && (wait_cnt >= wait_cfg);
  assign imem_rdata = mem[imem_addr];

  always @(posedge clk) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  function automatic logic [31:0] exp_fields(input logic [31:0] w);
    int f_imm, f_rs1, f_f3, f_rd;
    f_imm = int'(w >> 20) & 'hFFF;
    f_rs1 = int'(w >> 15) & 'h1F;
    f_f3  = int'(w >> 12) & 'h7;
    f_rd  = int'(w >> 7)  & 'h1F;
    return 32'((f_imm << 13) + (f_rs1 << 8) + (f_f3 << 5) + f_rd);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic e_req, input int e_pc,
                             input logic [31:0] e_fields, input logic e_issue,
                             input logic e_halt, input logic e_ill);
    chk({tag, ".req"},     32'(imem_req), 32'(e_req));
    chk({tag, ".addr"},    32'(imem_addr), 32'(e_pc % DEPTH));
    chk({tag, ".fields"},  32'({imm12, rs1, opcode, rd}), e_fields);
    chk({tag, ".issue"},   32'(issue), 32'(e_issue));
    chk({tag, ".halt"},    32'(halt), 32'(e_halt));
    chk({tag, ".illegal"}, 32'(illegal), 32'(e_ill));
  endtask

  // Starts one cycle before FETCH; walks fetch, then hold or halt.
  task automatic do_instr(input string tag, input logic [31:0] word, input int waits,
                          input logic run_after, input bit wiggle);
    bit is_op_imm;
    bit is_ecall;
    wait_cfg  = waits;
    mem[pc % DEPTH] = word;
    is_op_imm = ((word % 128) == 32'h13);
    is_ecall  = (word == 32'h73);
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      if (wiggle) run = 1'($urandom_range(0, 1));
      chk_outputs({tag, ".fetch"}, 1'b1, pc, 32'h0, 1'b0, 1'b0, 1'b0);
    end
    if (is_op_imm) begin
      for (int h = 0; h < int'(HOLD); h++) begin
        @(negedge clk);
        chk_outputs({tag, ".hold"}, 1'b0, pc, exp_fields(word), (h == 0), 1'b0, 1'b0);
        if (h == int'(HOLD) - 1) run = run_after;
      end
      pc = (pc + 1) % DEPTH;
    end else begin
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        chk_outputs({tag, ".halt"}, 1'b0, pc, 32'h0, 1'b0, 1'b1, !is_ecall);
      end
    end
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_outputs({tag, ".idle"}, 1'b0, pc, 32'h0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    pc  = 0;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    run = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'h0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk_outputs("reset", 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // addi x1, x0, 5 then ECALL
    run = 1'b1;
    do_instr("addi", 32'h0050_0093, 0, 1'b1, 1'b0);
    do_instr("ecall", 32'h0000_0073, 0, 1'b1, 1'b0);

    // R-type add halts as illegal
    do_reset();
    run = 1'b1;
    do_instr("rtype", 32'h0000_0033, 0, 1'b1, 1'b0);

    // Three wait cycles, then PC wrap through all four words, then stop mid-stream
    do_reset();
    run = 1'b1;
    do_instr("slow", 32'hFFF0_A113, 3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      w = ($urandom & 32'hFFFF_FF80) | 32'h13;
      do_instr("fill", w, i, 1'b1, 1'b0);
    end
    do_instr("wrap", 32'h0070_F193, 1, 1'b0, 1'b0);
    idle_cycles("stopped", 5);

    // Reset in the second hold cycle
    run = 1'b1;
    wait_cfg = 0;
    mem[pc % DEPTH] = 32'h0010_8113;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    pc = 0;
    chk_outputs("midhold_rst", 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle_cycles("post_rst", 3);
    run = 1'b1;
    do_instr("after_rst", 32'h8001_4213, 0, 1'b1, 1'b0);

    // Randomised OP-IMM stream with random memory latency and run toggling in fetch
    for (int i = 0; i < 24; i++) begin
      w = ($urandom & 32'hFFFF_FF80) | 32'h13;
      do_instr("rand", w, int'($urandom_range(0, 3)), (i != 23), 1'b1);
    end
    idle_cycles("rand_end", 3);

    // Random non-OP-IMM word halts as illegal
    w = $urandom;
    if ((w % 128) == 32'h13) w = w ^ 32'h1;
    if (w == 32'h73) w = 32'h33;
    run = 1'b1;
    do_instr("rand_ill", w, int'($urandom_range(0, 2)), 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Instruction fetch and decode stage for the riscv32 datapath, upstream of the ALU/register-file top. It fetches 32-bit RV32I words from a word-addressed instruction memory with a req/ack handshake. It decodes OP-IMM (I-type ALU) instructions into the `opcode`/`rd`/`rs1`/`imm12` fields the datapath consumes, and holds each instruction's fields stable for a fixed number of cycles. ECALL halts the stage; any other major opcode flags illegal and halts.

## Interface
- `WIDTH`, 32: instruction and data width; must be 32.
- `PC_BITS`, 8: word-address width; PC wraps modulo 2^PC_BITS.
- `HOLD_CYCLES`, 3: cycles each decoded instruction is presented; must be ≥1.

- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `run`  in  1: fetch enable, sampled at each IDLE exit and at each HOLD end.
- `imem_req`  out  1: fetch request, held until ack.
- `imem_addr`  out  PC_BITS: word address, equals PC, stable while `imem_req`.
- `imem_ack`  in  1: `imem_rdata` valid this cycle; ignored unless `imem_req`.
- `imem_rdata`  in  WIDTH: fetched instruction.
- `opcode`  out  3: funct3, `imem_rdata[14:12]`.
- `rd`  out  5: `imem_rdata[11:7]`.
- `rs1`  out  5: `imem_rdata[19:15]`.
- `imm12`  out  12: `imem_rdata[31:20]`, raw (no sign extension).
- `issue`  out  1: one-cycle pulse in the first HOLD cycle of each instruction.
- `halt`  out  1: sticky; set when HALT is entered.
- `illegal`  out  1: sticky; set when the halting instruction was not ECALL.

## Operation
- FSM states: IDLE, FETCH, HOLD, HALT. Reset state is IDLE.
- Reset values: PC=0, hold counter=0, `imem_req`=0, `issue`=0, `halt`=0, `illegal`=0. Fields reset to NOP: `opcode`=0, `rd`=0, `rs1`=0, `imm12`=0 (addi x0,x0,0).
- IDLE: outputs NOP. If `run`=1, go to FETCH.
- FETCH: `imem_req`=1, `imem_addr`=PC. The request is never abandoned, even if `run` drops. When `imem_ack`=1, classify `imem_rdata`:
  - `[6:0]`=0010011 (OP-IMM, every funct3 including shifts): load the field registers, clear the hold counter, go to HOLD.
  - `imem_rdata`=0x00000073 (ECALL): go to HALT with `halt`=1 and `illegal`=0.
  - Anything else: go to HALT with `halt`=1 and `illegal`=1.
- HOLD: fields are stable and the counter increments. When counter = HOLD_CYCLES-1:
  - PC ← PC+1 (2^PC_BITS-1 wraps to 0).
  - Fields return to NOP.
  - Next state is FETCH if `run`=1, otherwise IDLE.
- HALT: fields NOP, `imem_req`=0, PC frozen. Only `rst` exits this state.
- Outside HOLD the fields are always NOP, so the datapath executes only harmless x0 writes between instructions.
- `rst` in any state, including mid-FETCH or mid-HOLD, returns the stage to reset values at the next edge. A pending fetch is dropped and a late `imem_ack` is ignored.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from an input to an output.
- Zero-wait memory (ack in the same cycle as req), with `run` seen high at edge 0:
  - FETCH in cycle 1.
  - Fields valid and `issue`=1 in cycle 2.
  - Fields held through cycle 1+HOLD_CYCLES.
  - Next FETCH in cycle 2+HOLD_CYCLES.
  - Steady-state period is HOLD_CYCLES+1 cycles per instruction.
- Each wait cycle of memory (req high, ack low) adds one cycle. During wait cycles `imem_addr` does not change and fields stay NOP.
- HALT is entered on the edge after the ack; `halt` is visible in that next cycle.
- `issue` is high for exactly one cycle per decoded OP-IMM and never in IDLE, FETCH or HALT.

## Structure
- Shared package `riscv_pkg`:
  - `fetch_state` enum (IDLE, FETCH, HOLD, HALT).
  - `OPC_OP_IMM`=7'b0010011.
  - `INSTR_ECALL`=32'h00000073.
  - NOP field constants.
- Sub-module `itype_decode`: combinational field slicing plus is-op-imm and is-ecall flags. `fetch_decode` owns PC, FSM, hold counter and the field registers.

## Test plan
- Reset, `run`=1, zero-wait memory with mem[0]=0x00500093 → `imem_addr`=0. Fields `opcode`=0, `rd`=1, `rs1`=0, `imm12`=0x005 for 3 cycles, `issue` pulses once, next `imem_addr`=1.
- mem[1]=0x00000073 → `halt`=1, `illegal`=0, `imem_req` stays 0 for 20 cycles, fields NOP.
- mem[0]=0x00000033 (R-type add) → `halt`=1, `illegal`=1, `issue` never asserted.
- Ack delayed 3 cycles for mem[0]=0xFFF0A113 → `imem_req`=1 and `imem_addr`=0 stable for 4 cycles, then `rd`=2, `rs1`=1, `imm12`=0xFFF.
- `PC_BITS`=2, four OP-IMM words → fifth fetch has `imem_addr`=0. Drop `run` mid-HOLD → hold completes, PC advances, IDLE, no new `imem_req`.
- `rst` asserted in the second HOLD cycle → next cycle fields NOP, `issue`=0, PC=0, state IDLE, `imem_req`=0.
